// File: rtl/gate_level_pkg.sv
// Shared constants for the gate_level teaching cell: golden truth tables indexed by {a,b,c}.
package gate_level_pkg;

  localparam int unsigned N_IN  = 3;
  localparam int unsigned N_ROW = 1 << N_IN;

  localparam logic [N_ROW-1:0] F0_TRUTH = 8'b1100_1010;
  localparam logic [N_ROW-1:0] F1_TRUTH = 8'b1001_0110;

  typedef enum logic [2:0] {
    VAR_Y0,
    VAR_Y0_2,
    VAR_Y0_3,
    VAR_Y0_4,
    VAR_Y1,
    VAR_Y1_2
  } variant_e;

  function automatic logic f0_ref(input logic [N_IN-1:0] idx);
    return F0_TRUTH[idx];
  endfunction

  function automatic logic f1_ref(input logic [N_IN-1:0] idx);
    return F1_TRUTH[idx];
  endfunction

endpackage

// File: rtl/gate_level_if.sv
// Function inputs and the six registered variant outputs of gate_level.
interface gate_level_if;
  logic a;
  logic b;
  logic c;
  logic Y0;
  logic Y0_2;
  logic Y0_3;
  logic Y0_4;
  logic Y1;
  logic Y1_2;

  modport master (output a, b, c, input Y0, Y0_2, Y0_3, Y0_4, Y1, Y1_2);
  modport slave  (input a, b, c, output Y0, Y0_2, Y0_3, Y0_4, Y1, Y1_2);
endinterface

// File: rtl/gl_dff.sv
// D flip-flop with asynchronous active-high clear.
module gl_dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

// File: rtl/gate_level.sv
// Two 3-input functions, each realised by several gate-level netlists, every
// variant registered so combinational hazards never reach the outputs.
module gate_level
  import gate_level_pkg::*;
#(
  parameter int unsigned GATE_DELAY = 0
) (
  input logic        clk,
  input logic        rst,
  gate_level_if.slave bus
);

  logic a, b, c;
  assign a = bus.a;
  assign b = bus.b;
  assign c = bus.c;

  // F0 = a*b + a'*c, plain two-level SOP; glitches on a falling with b=c=1
  logic na, t_ab, t_nac, y0_net;
  not #(GATE_DELAY) g0_na  (na, a);
  and #(GATE_DELAY) g0_ab  (t_ab, a, b);
  and #(GATE_DELAY) g0_nac (t_nac, na, c);
  or  #(GATE_DELAY) g0_or  (y0_net, t_ab, t_nac);

  // Same SOP plus consensus b*c, which covers the a-transition
  logic na2, t2_ab, t2_nac, t2_bc, y0_2_net;
  not #(GATE_DELAY) g1_na  (na2, a);
  and #(GATE_DELAY) g1_ab  (t2_ab, a, b);
  and #(GATE_DELAY) g1_nac (t2_nac, na2, c);
  and #(GATE_DELAY) g1_bc  (t2_bc, b, c);
  or  #(GATE_DELAY) g1_or  (y0_2_net, t2_ab, t2_nac, t2_bc);

  // NAND-NAND form; the inverter is a tied-input NAND
  logic n_a, n_ab, n_nac, y0_3_net;
  nand #(GATE_DELAY) g2_na  (n_a, a, a);
  nand #(GATE_DELAY) g2_ab  (n_ab, a, b);
  nand #(GATE_DELAY) g2_nac (n_nac, n_a, c);
  nand #(GATE_DELAY) g2_out (y0_3_net, n_ab, n_nac);

  // NOR-NOR form of (a + c)(a' + b)
  logic r_na, r_ac, r_nab, y0_4_net;
  nor #(GATE_DELAY) g3_na  (r_na, a, a);
  nor #(GATE_DELAY) g3_ac  (r_ac, a, c);
  nor #(GATE_DELAY) g3_nab (r_nab, r_na, b);
  nor #(GATE_DELAY) g3_out (y0_4_net, r_ac, r_nab);

  // F1 = a ^ b ^ c as an XOR chain
  logic x_ab, y1_net;
  xor #(GATE_DELAY) g4_ab  (x_ab, a, b);
  xor #(GATE_DELAY) g4_out (y1_net, x_ab, c);

  // F1 as AND-OR over minterms 1, 2, 4, 7
  logic m_na, m_nb, m_nc, m1, m2, m4, m7, y1_2_net;
  not #(GATE_DELAY) g5_na (m_na, a);
  not #(GATE_DELAY) g5_nb (m_nb, b);
  not #(GATE_DELAY) g5_nc (m_nc, c);
  and #(GATE_DELAY) g5_m1 (m1, m_na, m_nb, c);
  and #(GATE_DELAY) g5_m2 (m2, m_na, b, m_nc);
  and #(GATE_DELAY) g5_m4 (m4, a, m_nb, m_nc);
  and #(GATE_DELAY) g5_m7 (m7, a, b, c);
  or  #(GATE_DELAY) g5_or (y1_2_net, m1, m2, m4, m7);

  gl_dff u_y0   (.clk(clk), .rst(rst), .d(y0_net),   .q(bus.Y0));
  gl_dff u_y0_2 (.clk(clk), .rst(rst), .d(y0_2_net), .q(bus.Y0_2));
  gl_dff u_y0_3 (.clk(clk), .rst(rst), .d(y0_3_net), .q(bus.Y0_3));
  gl_dff u_y0_4 (.clk(clk), .rst(rst), .d(y0_4_net), .q(bus.Y0_4));
  gl_dff u_y1   (.clk(clk), .rst(rst), .d(y1_net),   .q(bus.Y1));
  gl_dff u_y1_2 (.clk(clk), .rst(rst), .d(y1_2_net), .q(bus.Y1_2));

endmodule

// File: tb/tb_gate_level.sv
// Directed bench for gate_level: scoreboard of expected F0/F1 per driven input.
module tb_gate_level;
  import gate_level_pkg::*;

  typedef struct packed {
    logic f0;
    logic f1;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  gate_level_if bus ();

  gate_level #(.GATE_DELAY(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic f0, input logic f1);
    chk({tag, ".Y0"},   bus.Y0,   f0);
    chk({tag, ".Y0_2"}, bus.Y0_2, f0);
    chk({tag, ".Y0_3"}, bus.Y0_3, f0);
    chk({tag, ".Y0_4"}, bus.Y0_4, f0);
    chk({tag, ".Y1"},   bus.Y1,   f1);
    chk({tag, ".Y1_2"}, bus.Y1_2, f1);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk_all(tag, e.f0, e.f1);
    end
  endtask

  task automatic drive(input logic [2:0] v);
    bus.a = v[2];
    bus.b = v[1];
    bus.c = v[0];
  endtask

  // One input per cycle: drive at negedge, check just after the capturing edge
  task automatic step(input string tag, input logic [2:0] v, input logic f0, input logic f1);
    @(negedge clk);
    drive(v);
    sb.push_back('{f0: f0, f1: f1});
    @(posedge clk);
    #1;
    sb_check(tag);
  endtask

  logic [2:0] gray_in [9];
  logic       gray_y0 [9];
  logic       gray_y1 [9];

  initial begin
    checks  = 0;
    errors  = 0;
    gray_in = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    gray_y0 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    gray_y1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset held with all-ones inputs while the clock runs
    rst = 1'b1;
    drive(3'b111);
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset_hold", 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{f0: 1'b1, f1: 1'b1});
    #1;
    chk_all("reset_released_no_edge", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    sb_check("reset_first_capture");

    for (int i = 0; i < 9; i++)
      step($sformatf("gray_%0d", i), gray_in[i], gray_y0[i], gray_y1[i]);

    for (int v = 0; v < 8; v++)
      step($sformatf("equiv_%0d", v), 3'(v), F0_TRUTH[v], F1_TRUTH[v]);

    // 111 -> 011 mid-cycle: the raw Y0 net may pulse low, the register must not
    step("haz_pre", 3'b111, 1'b1, 1'b1);
    @(negedge clk);
    drive(3'b011);
    sb.push_back('{f0: 1'b1, f1: 1'b0});
    #2;
    chk("haz_mid_a.Y0", bus.Y0, 1'b1);
    #1;
    chk("haz_mid_b.Y0", bus.Y0, 1'b1);
    @(posedge clk);
    #1;
    sb_check("haz_post");

    // Asynchronous reset between edges
    step("arst_pre", 3'b110, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("arst_immediate", 1'b0, 1'b0);
    @(negedge clk);
    chk_all("arst_held", 1'b0, 1'b0);
    rst = 1'b0;
    sb.push_back('{f0: 1'b1, f1: 1'b0});
    #1;
    chk_all("arst_released_no_edge", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    sb_check("arst_first_capture");

    // Inputs disturbed and restored between edges leave outputs untouched
    step("hold_pre", 3'b101, 1'b0, 1'b0);
    #1;
    drive(3'b010);
    #2;
    chk_all("hold_disturbed", 1'b0, 1'b0);
    @(negedge clk);
    drive(3'b101);
    sb.push_back('{f0: 1'b0, f1: 1'b0});
    @(posedge clk);
    #1;
    sb_check("hold_post");

    chk("scoreboard_drained", 1'(sb.size() == 0), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
